btn_conditioner: RTL and testbench

Per-button input conditioner between the board push-buttons and the reaction-timer FSM. Each raw button is synchronised into the 100 MHz domain, debounced with a stable-cycle counter, and turned into a clean level plus single-cycle press and release pulses. The reaction timer uses `BTN_PRESS[0]` for start/stop (BTNC) and `BTN_PRESS[1]` for clear (BTNU), so a single physical press produces exactly one event.

---
 rtl/btn_conditioner.sv | 119 +++++++++++
 tb/tb_btn_conditioner.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop sync, stable-count debounce, registered press/release pulses.
// Define BTN_LONG_PRESS_EN to add the per-channel hold counter and the BTN_LONG output.

module btn_chan #(
    parameter int DEBOUNCE_CYC = 1_000_000
`ifdef BTN_LONG_PRESS_EN
   ,parameter int LONG_CYC     = 100_000_000
`endif
) (
    input  logic CLK100MHZ,
    input  logic RST,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
`ifdef BTN_LONG_PRESS_EN
   ,output logic btn_long
`endif
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

    logic          sync1, sync2;
    logic [DW-1:0] db_cnt;
    logic          accept;

    // btn_level doubles as the RELEASED/PRESSED state bit
    assign accept = (sync2 != btn_level) && (db_cnt == DB_LAST);

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            db_cnt      <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            sync1       <= btn_raw;
            sync2       <= sync1;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            if (sync2 == btn_level) begin
                db_cnt <= '0;
            end else if (accept) begin
                db_cnt      <= '0;
                btn_level   <= ~btn_level;
                btn_press   <= ~btn_level;
                btn_release <= btn_level;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYC + 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYC - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYC);

    logic [LW-1:0] hold_cnt;

    // Saturating at LONG_MAX gives one event per hold, never a repeat
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            hold_cnt <= '0;
            btn_long <= 1'b0;
        end else begin
            btn_long <= 1'b0;
            if (!btn_level || accept) begin
                hold_cnt <= '0;
            end else if (hold_cnt != LONG_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt == LONG_LAST)
                    btn_long <= 1'b1;
            end
        end
    end
`endif
endmodule

module btn_conditioner #(
    parameter int N_BTN        = 2,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 100_000_000
) (
    input  logic             CLK100MHZ,
    input  logic             RST,
    input  logic [N_BTN-1:0] BTN_RAW,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_RELEASE
`ifdef BTN_LONG_PRESS_EN
   ,output logic [N_BTN-1:0] BTN_LONG
`endif
);
    if (DEBOUNCE_CYC < 1 || LONG_CYC < 1) begin : g_bad_param
        $error("btn_conditioner: DEBOUNCE_CYC and LONG_CYC must be >= 1");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_chan #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
`ifdef BTN_LONG_PRESS_EN
           ,.LONG_CYC    (LONG_CYC)
`endif
        ) u_chan (
            .CLK100MHZ  (CLK100MHZ),
            .RST        (RST),
            .btn_raw    (BTN_RAW[i]),
            .btn_level  (BTN_LEVEL[i]),
            .btn_press  (BTN_PRESS[i]),
            .btn_release(BTN_RELEASE[i])
`ifdef BTN_LONG_PRESS_EN
           ,.btn_long   (BTN_LONG[i])
`endif
        );
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYC=4, LONG_CYC=20.
module tb_btn_conditioner;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] raw;
    logic [1:0] level, press, rel;
`ifdef BTN_LONG_PRESS_EN
    logic [1:0] long_p;
`endif

    int checks   = 0;
    int failures = 0;

    // Event counters kept by a free-running monitor; the stimulus only reads them
    int press0_n = 0, press1_n = 0, rel0_n = 0, long0_n = 0;
    int dbl_n = 0, overlap_n = 0;
    logic [1:0] press_q = 2'b00;

    btn_conditioner #(.N_BTN(2), .DEBOUNCE_CYC(4), .LONG_CYC(20)) dut (
        .CLK100MHZ  (clk),
        .RST        (rst),
        .BTN_RAW    (raw),
        .BTN_LEVEL  (level),
        .BTN_PRESS  (press),
        .BTN_RELEASE(rel)
`ifdef BTN_LONG_PRESS_EN
       ,.BTN_LONG   (long_p)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (press[0]) press0_n++;
        if (press[1]) press1_n++;
        if (rel[0])   rel0_n++;
        if ((press & press_q) != 2'b00) dbl_n++;
        if ((press & rel) != 2'b00)     overlap_n++;
`ifdef BTN_LONG_PRESS_EN
        if (long_p[0]) long0_n++;
`endif
        press_q = press;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int p0, r0, p1, l0;
        rst = 1'b1;
        raw = 2'b00;
        step(3);
        chk("rst_level", level, 2'b00);
        chk("rst_press", press, 2'b00);
        chk("rst_release", rel, 2'b00);
        rst = 1'b0;
        step(2);

        // Clean press on channel 0: pulse after edge E+5
        p0 = press0_n;
        raw = 2'b01;
        step(5);
        chk("clean_early_level", level, 2'b00);
        chk("clean_early_press", press, 2'b00);
        step(1);
        chk("clean_level", level, 2'b01);
        chk("clean_press", press, 2'b01);
        chk("clean_release", rel, 2'b00);
        step(1);
        chk("clean_press_clr", press, 2'b00);
        chk("clean_press_once", press0_n - p0, 1);

        // Release with the same latency
        r0 = rel0_n;
        raw = 2'b00;
        step(5);
        chk("rel_early_level", level, 2'b01);
        step(1);
        chk("rel_level", level, 2'b00);
        chk("rel_pulse", rel, 2'b01);
        chk("rel_press_low", press, 2'b00);
        step(1);
        chk("rel_pulse_clr", rel, 2'b00);
        chk("rel_once", rel0_n - r0, 1);
        step(3);

        // Bounce 1,0,1,1,0 then a stable 1
        p0 = press0_n;
        raw = 2'b01; step(1);
        raw = 2'b00; step(1);
        raw = 2'b01; step(1);
        raw = 2'b01; step(1);
        raw = 2'b00; step(1);
        raw = 2'b01;
        step(5);
        chk("bounce_quiet_level", level, 2'b00);
        chk("bounce_quiet_press", press0_n - p0, 0);
        step(1);
        chk("bounce_press", press, 2'b01);
        step(3);
        chk("bounce_press_once", press0_n - p0, 1);
        raw = 2'b00;
        step(8);
        chk("bounce_released", level, 2'b00);

        // Simultaneous press on both channels
        p1 = press1_n;
        raw = 2'b11;
        step(5);
        chk("simul_early", press, 2'b00);
        step(1);
        chk("simul_press", press, 2'b11);
        chk("simul_level", level, 2'b11);
        step(1);
        chk("simul_press_clr", press, 2'b00);
        chk("simul_ch1_once", press1_n - p1, 1);
        raw = 2'b00;
        step(8);

        // Reset with ch0 mid-debounce (db_cnt=2) and ch1 held through reset
        raw = 2'b01;
        step(4);
        rst = 1'b1;
        raw = 2'b11;
        step(2);
        chk("rstmid_level", level, 2'b00);
        chk("rstmid_press", press, 2'b00);
        rst = 1'b0;
        step(5);
        chk("rstmid_early", press, 2'b00);
        step(1);
        chk("rstmid_press_after", press, 2'b11);
        step(2);
        // Reset must drop a settled level, and the held button counts as a new press
        rst = 1'b1;
        step(1);
        chk("rst_clears_level", level, 2'b00);
        rst = 1'b0;
        step(5);
        chk("rehold_early", press, 2'b00);
        step(1);
        chk("rehold_press", press, 2'b11);
        raw = 2'b00;
        step(8);

`ifdef BTN_LONG_PRESS_EN
        // 30-cycle hold fires BTN_LONG exactly 20 cycles after BTN_PRESS
        l0 = long0_n;
        raw = 2'b01;
        step(6);
        chk("long_press", press, 2'b01);
        step(19);
        chk("long_early", long_p, 2'b00);
        step(1);
        chk("long_pulse", long_p, 2'b01);
        step(1);
        chk("long_pulse_clr", long_p, 2'b00);
        step(8);
        raw = 2'b00;
        step(8);
        chk("long_once", long0_n - l0, 1);

        // Release accepted ~15 cycles after the press: no long event
        l0 = long0_n;
        raw = 2'b01;
        step(6);
        step(9);
        raw = 2'b00;
        step(20);
        chk("short_no_long", long0_n - l0, 0);
`else
        l0 = long0_n;
        chk("no_long_port", long0_n - l0, 0);
`endif

        chk("no_double_press", dbl_n, 0);
        chk("no_press_release_overlap", overlap_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
